class_vec_sequencer: RTL

CLASS_VEC_SEQUENCER -- requirements
Module: class_vec_sequencer

---
 rtl/class_vec_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/class_vec_sequencer.sv
// class_vec_sequencer: sweeps (class, frame) pairs through an external generator and streams registered vectors; CLASS_SEQ_MASK_EN adds per-class skipping via class_mask.
module class_vec_sequencer #(
  parameter int DIM = 64,
  parameter int NUM_CLASSES = 8,
  parameter int NUM_FRAMES = 3,
  parameter int ID_W = 3,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [ID_W-1:0]        frame_id,
  output logic [IDX_W-1:0]       frame_index,
  input  logic [DIM-1:0]         gen_vec,
`ifdef CLASS_SEQ_MASK_EN
  input  logic [NUM_CLASSES-1:0] class_mask,
`endif
  output logic [DIM-1:0]         out_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ID_W-1:0]        out_id,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] id_q, id_d, out_id_q, out_id_d, first_id, next_id, last_id;
  logic [IDX_W-1:0] idx_q, idx_d, out_idx_q, out_idx_d;
  logic [DIM-1:0] out_vec_q, out_vec_d;
  logic out_last_q, out_last_d, at_end;
  logic [NUM_CLASSES-1:0] mask, start_mask;
`ifdef CLASS_SEQ_MASK_EN
  logic [NUM_CLASSES-1:0] mask_q, mask_d;
  assign start_mask = class_mask;
  assign mask = mask_q;
  assign mask_d = (state_q == IDLE && start) ? class_mask : mask_q;
`else
  assign start_mask = '1;
  assign mask = '1;
`endif
  assign at_end = idx_q == IDX_W'(NUM_FRAMES - 1);
  // lowest enabled class overall / above id_q, highest enabled class
  always_comb begin
    first_id = '0;
    next_id = id_q;
    last_id = '0;
    for (int c = NUM_CLASSES - 1; c >= 0; c--) begin
      if (start_mask[c]) first_id = ID_W'(c);
      if (mask[c] && ID_W'(c) > id_q) next_id = ID_W'(c);
    end
    for (int c = 0; c < NUM_CLASSES; c++)
      if (mask[c]) last_id = ID_W'(c);
  end
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    idx_d = idx_q;
    out_vec_d = out_vec_q;
    out_id_d = out_id_q;
    out_idx_d = out_idx_q;
    out_last_d = out_last_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = |start_mask ? FETCH : DONE;
        id_d = first_id;
        idx_d = '0;
      end
      FETCH: if (abort) state_d = DONE;
      else begin
        state_d = SEND;
        out_vec_d = gen_vec;
        out_id_d = id_q;
        out_idx_d = idx_q;
        out_last_d = at_end && id_q == last_id;
      end
      SEND: if (abort) state_d = DONE;
      else if (out_ready) begin
        state_d = out_last_q ? DONE : FETCH;
        idx_d = at_end ? '0 : idx_q + 1'b1;
        id_d = at_end ? next_id : id_q;
      end
      default: begin
        state_d = IDLE;
        id_d = '0;
        idx_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q <= '0;
      idx_q <= '0;
      out_vec_q <= '0;
      out_id_q <= '0;
      out_idx_q <= '0;
      out_last_q <= 1'b0;
`ifdef CLASS_SEQ_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      idx_q <= idx_d;
      out_vec_q <= out_vec_d;
      out_id_q <= out_id_d;
      out_idx_q <= out_idx_d;
      out_last_q <= out_last_d;
`ifdef CLASS_SEQ_MASK_EN
      mask_q <= mask_d;
`endif
    end
  end
  assign frame_id = (state_q == FETCH || state_q == SEND) ? id_q : '0;
  assign frame_index = (state_q == FETCH || state_q == SEND) ? idx_q : '0;
  assign out_vec = out_vec_q;
  assign out_id = out_id_q;
  assign out_idx = out_idx_q;
  assign out_last = out_last_q;
  assign out_valid = state_q == SEND;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule
